bcd_time_counter: RTL and testbench

Upstream source for the six-digit seven-segment display bank.
- Keeps 24-hour time of day as HH:MM:SS in packed BCD. Drives a 24-bit bus, one nibble per display digit, plus per-digit blank flags, straight into the six sevenseg decoder instances.
- Set mode lets the user adjust hours, minutes or seconds with a single increment input.
- The selected field blinks while it is being set.

---
 rtl/bcd_time_counter_pkg.sv | 45 ++++
 rtl/bcd_time_counter_mod.sv | 33 +++
 rtl/bcd_time_counter.sv | 103 ++++++++++
 tb/tb_bcd_time_counter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_time_counter_pkg.sv
// Shared constants for the HH:MM:SS BCD time counter: field selects,
// field limits and the blank-bit index of each display digit.
package bcd_time_counter_pkg;

    typedef enum logic [1:0] {
        FIELD_SEC  = 2'd0,
        FIELD_MIN  = 2'd1,
        FIELD_HR   = 2'd2,
        FIELD_NONE = 2'd3
    } field_t;

    localparam int SEC_LIMIT = 59;
    localparam int MIN_LIMIT = 59;
    localparam int HR_LIMIT  = 23;

    localparam int DIG_SEC_U = 0;
    localparam int DIG_SEC_T = 1;
    localparam int DIG_MIN_U = 2;
    localparam int DIG_MIN_T = 3;
    localparam int DIG_HR_U  = 4;
    localparam int DIG_HR_T  = 5;

    // Blank mask covering both digits of the given field; FIELD_NONE blanks nothing.
    function automatic logic [5:0] field_mask(input logic [1:0] field);
        logic [5:0] mask;
        mask = '0;
        case (field)
            FIELD_SEC: begin
                mask[DIG_SEC_U] = 1'b1;
                mask[DIG_SEC_T] = 1'b1;
            end
            FIELD_MIN: begin
                mask[DIG_MIN_U] = 1'b1;
                mask[DIG_MIN_T] = 1'b1;
            end
            FIELD_HR: begin
                mask[DIG_HR_U] = 1'b1;
                mask[DIG_HR_T] = 1'b1;
            end
            default: mask = '0;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/bcd_time_counter_mod.sv
// Two-digit packed-BCD counter that wraps LIMIT -> 00; carry flags the wrap.
module bcd_mod_counter #(
    parameter int LIMIT = 59
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic       clr,
    output logic [7:0] value,
    output logic       carry
);

    localparam logic [7:0] LIMIT_BCD = {4'(LIMIT / 10), 4'(LIMIT % 10)};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value <= 8'h00;
        end else if (clr) begin
            value <= 8'h00;
        end else if (en) begin
            if (value == LIMIT_BCD) begin
                value <= 8'h00;
            end else if (value[3:0] == 4'd9) begin
                value <= {value[7:4] + 4'd1, 4'd0};
            end else begin
                value <= {value[7:4], value[3:0] + 4'd1};
            end
        end
    end

    assign carry = en && (value == LIMIT_BCD);

endmodule

// File: rtl/bcd_time_counter.sv
// 24-hour HH:MM:SS BCD clock with tick prescaler, set mode and blinking
// of the field being set; feeds the six-digit seven-segment bank.
module bcd_time_counter
    import bcd_time_counter_pkg::*;
#(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        run,
    input  logic [1:0]  sel,
    input  logic        inc,
    input  logic        clr,
    output logic [23:0] bcd,
    output logic [5:0]  blank,
    output logic        tick
);

    localparam int P     = CLK_HZ / TICK_HZ;
    localparam int CNT_W = $clog2(P);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(P - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(P / 2);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             run_q;
    logic             run_rise;
    logic             sec_en, min_en, hr_en;
    logic             sec_carry, min_carry;
    logic [7:0]       sec_val, min_val, hr_val;

    assign run_rise = run && !run_q;

    // Restarting the prescaler on a run edge makes the first tick land P cycles later.
    always_comb begin
        count_next = count + 1'b1;
        if (clr || run_rise || count == LAST) begin
            count_next = '0;
        end
    end

    // tick is computed from the next count so it is high exactly while count == P-1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            tick  <= 1'b0;
            run_q <= 1'b0;
            blank <= '0;
        end else begin
            count <= count_next;
            tick  <= (count_next == LAST);
            run_q <= run;
            blank <= (!run && count >= HALF) ? field_mask(sel) : 6'b000000;
        end
    end

    // Run mode chains carries; set mode bumps only the selected field.
    always_comb begin
        sec_en = 1'b0;
        min_en = 1'b0;
        hr_en  = 1'b0;
        if (run) begin
            sec_en = tick;
            min_en = sec_carry;
            hr_en  = min_carry;
        end else if (inc) begin
            sec_en = (sel == FIELD_SEC);
            min_en = (sel == FIELD_MIN);
            hr_en  = (sel == FIELD_HR);
        end
    end

    bcd_mod_counter #(.LIMIT(SEC_LIMIT)) u_sec (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (sec_en),
        .clr     (clr),
        .value   (sec_val),
        .carry   (sec_carry)
    );

    bcd_mod_counter #(.LIMIT(MIN_LIMIT)) u_min (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (min_en),
        .clr     (clr),
        .value   (min_val),
        .carry   (min_carry)
    );

    bcd_mod_counter #(.LIMIT(HR_LIMIT)) u_hr (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (hr_en),
        .clr     (clr),
        .value   (hr_val),
        .carry   ()
    );

    assign bcd = {hr_val, min_val, sec_val};

endmodule

// File: tb/tb_bcd_time_counter.sv
// Self-checking bench for bcd_time_counter (P = 10) against a seconds-of-day
// reference model, with directed scenarios followed by random traffic.
module tb_bcd_time_counter;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b1;
    logic        run     = 1'b0;
    logic [1:0]  sel     = 2'd3;
    logic        inc     = 1'b0;
    logic        clr     = 1'b0;
    logic [23:0] bcd;
    logic [5:0]  blank;
    logic        tick;

    int total = 0;
    int bad   = 0;

    int         mH, mM, mS, mCnt;
    bit         mRunQ, mTick;
    logic [5:0] mBlank;

    bcd_time_counter #(.CLK_HZ(10), .TICK_HZ(1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (run),
        .sel     (sel),
        .inc     (inc),
        .clr     (clr),
        .bcd     (bcd),
        .blank   (blank),
        .tick    (tick)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] toBcd(input int h, input int m, input int s);
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic modelReset();
        mH = 0; mM = 0; mS = 0; mCnt = 0;
        mRunQ = 0; mTick = 0; mBlank = '0;
    endtask

    // Reference behaviour for one rising edge, using the inputs of the cycle just ending.
    task automatic modelEdge();
        int secs;
        int nextCnt;
        if (clr) begin
            mH = 0; mM = 0; mS = 0;
        end else if (run) begin
            if (mTick) begin
                secs = (mH * 3600 + mM * 60 + mS + 1) % 86400;
                mH = secs / 3600;
                mM = (secs / 60) % 60;
                mS = secs % 60;
            end
        end else if (inc) begin
            case (sel)
                2'd0: mS = (mS + 1) % 60;
                2'd1: mM = (mM + 1) % 60;
                2'd2: mH = (mH + 1) % 24;
                default: ;
            endcase
        end
        mBlank = 6'b000000;
        if (!run && mCnt >= 5) begin
            case (sel)
                2'd0: mBlank = 6'b000011;
                2'd1: mBlank = 6'b001100;
                2'd2: mBlank = 6'b110000;
                default: mBlank = 6'b000000;
            endcase
        end
        nextCnt = (clr || (run && !mRunQ)) ? 0 : (mCnt + 1) % 10;
        mTick = (nextCnt == 9);
        mCnt  = nextCnt;
        mRunQ = run;
    endtask

    task automatic checkVal(input string tag, input logic [23:0] got, input logic [23:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, ".bcd"}, bcd, toBcd(mH, mM, mS));
        checkVal({tag, ".blank"}, 24'(blank), 24'(mBlank));
        checkVal({tag, ".tick"}, 24'(tick), 24'(mTick));
    endtask

    task automatic applyStimulus(input logic r, input logic [1:0] s, input logic i,
                                 input logic c, input string tag);
        run = r; sel = s; inc = i; clr = c;
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput(tag);
    endtask

    task automatic pulseInc(input logic [1:0] s, input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'b0, s, 1'b1, 1'b0, tag);
            applyStimulus(1'b0, s, 1'b0, 1'b0, tag);
        end
    endtask

    // Runs with run=1 until the DUT ticks; returns how many edges that took (0 = never).
    task automatic runUntilTick(input int first, input logic doInc, input string tag, output int cycles);
        cycles = 0;
        for (int k = first; k <= 20; k++) begin
            applyStimulus(1'b1, 2'($urandom_range(0, 3)), doInc ? 1'($urandom) : 1'b0, 1'b0, tag);
            if (tick) begin
                cycles = k;
                break;
            end
        end
    endtask

    initial begin
        int cyc;
        int hits;
        logic [23:0] held;

        $display("[TB] start");
        #1 reset_n = 1'b0;
        modelReset();
        #10;
        checkOutput("reset0");
        @(posedge clk);
        #2 reset_n = 1'b1;

        // Run ten cycles, then drop reset mid-cycle and look before the next edge.
        run = 1'b1;
        for (int k = 0; k < 10; k++) applyStimulus(1'b1, 2'd3, 1'b0, 1'b0, "run1");
        #2 reset_n = 1'b0;
        modelReset();
        #1;
        checkOutput("asyncrst");
        @(posedge clk);
        #2 reset_n = 1'b1;
        runUntilTick(1, 1'b0, "rel", cyc);
        checkVal("firsttick_after_reset", 24'(cyc), 24'd10);

        // Set 23:59:59 field by field, then let one tick roll the day over.
        pulseInc(2'd0, 59, "setsec");
        pulseInc(2'd1, 59, "setmin");
        pulseInc(2'd2, 23, "sethr");
        checkVal("set235959", bcd, 24'h235959);
        runUntilTick(1, 1'b0, "wrapwait", cyc);
        checkVal("wrap_tick_delay", 24'(cyc), 24'd10);
        checkVal("wrap_pre", bcd, 24'h235959);
        applyStimulus(1'b1, 2'd3, 1'b0, 1'b0, "wrap");
        checkVal("wrap_post", bcd, 24'h000000);

        // Minutes wrap in set mode without carrying into hours; sel=3 ignores inc.
        pulseInc(2'd1, 59, "min59");
        pulseInc(2'd2, 7, "hr07");
        pulseInc(2'd1, 1, "minwrap");
        checkVal("minwrap_min", 24'(bcd[15:8]), 24'h00);
        checkVal("minwrap_hr", 24'(bcd[23:16]), 24'h07);
        held = bcd;
        pulseInc(2'd3, 2, "selnone");
        checkVal("selnone_hold", bcd, held);

        // Blink: half of every prescaler period blanks the selected pair.
        applyStimulus(1'b0, 2'd2, 1'b0, 1'b0, "blinkhr_warm");
        hits = 0;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 2'd2, 1'b0, 1'b0, "blinkhr");
            if (blank == 6'b110000) hits++;
        end
        checkVal("blinkhr_count", 24'(hits), 24'd5);
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, "blinksec_warm");
        hits = 0;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, "blinksec");
            if (blank == 6'b000011) hits++;
        end
        checkVal("blinksec_count", 24'(hits), 24'd5);
        for (int k = 0; k < 10; k++) applyStimulus(1'b1, 2'd0, 1'b0, 1'b0, "blinkrun");

        // 12:34:56, clr landing on the tick-high cycle.
        applyStimulus(1'b0, 2'd3, 1'b0, 1'b1, "clrset");
        pulseInc(2'd0, 56, "s56");
        pulseInc(2'd1, 34, "m34");
        pulseInc(2'd2, 12, "h12");
        checkVal("set123456", bcd, 24'h123456);
        runUntilTick(1, 1'b0, "clrwait", cyc);
        checkVal("clr_pre", bcd, 24'h123456);
        applyStimulus(1'b1, 2'd3, 1'b0, 1'b1, "clr");
        checkVal("clr_post", bcd, 24'h000000);
        runUntilTick(2, 1'b0, "clrnext", cyc);
        checkVal("clr_next_tick", 24'(cyc), 24'd10);

        // Random set-mode phase, then a run edge with stray inc pulses.
        repeat ($urandom_range(3, 15))
            applyStimulus(1'b0, 2'($urandom_range(0, 3)), 1'($urandom), 1'b0, "rndset");
        runUntilTick(1, 1'b1, "rndrun", cyc);
        checkVal("rnd_run_tick", 24'(cyc), 24'd10);

        // Mixed random traffic with occasional mode flips and clears.
        for (int k = 0; k < 600; k++) begin
            logic r;
            r = ($urandom_range(0, 19) == 0) ? !run : run;
            applyStimulus(r, 2'($urandom_range(0, 3)), 1'($urandom),
                          ($urandom_range(0, 49) == 0), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

endmodule
